mem_access_scheduler: RTL

- Single-port scheduler in front of the memory controller's BRAM.
- Shares the BRAM between requester 0, the priority input driven by the AXI-light controller, and requesters 1..N_REQ-1, the NoC bridge slave ports.
- Requester 0 has fixed priority, capped by a starvation limit. The remaining requesters are served round-robin.
- One transaction is in flight at a time: accept, issue, wait on read latency, respond.

---
 rtl/mem_access_scheduler_pkg.sv | 24 ++
 rtl/mem_access_scheduler_if.sv | 43 ++++
 rtl/mem_access_scheduler_rr_arbiter.sv | 32 +++
 rtl/mem_access_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_scheduler_pkg.sv
// Shared types and default sizing for the BRAM access scheduler.
// Imported by the interface, the arbiter and the scheduler top.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int N_REQ_DEF        = 3;
    localparam int MEM_DEPTH_DEF    = 16384;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int MEM_LATENCY_DEF  = 1;

    localparam int WADDR_W = $clog2(MEM_DEPTH_DEF);
    localparam int IDX_W   = $clog2(N_REQ_DEF);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_scheduler_if.sv
// Requester, response and BRAM signals of the access scheduler.
// slave = scheduler side, master = requesters/BRAM side.
interface mem_access_scheduler_if
    import mem_sched_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF
);
    localparam int MAW = $clog2(MEM_DEPTH);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*32-1:0]         req_wdata;
    logic [N_REQ*4-1:0]          req_wstrb;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [31:0]                 rsp_rdata;
    logic                        rsp_err;
    logic                        mem_en;
    logic [3:0]                  mem_we;
    logic [MAW-1:0]              mem_addr;
    logic [31:0]                 mem_wdata;
    logic [31:0]                 mem_rdata;
    logic                        busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_access_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after
// ptr_i, wrapping around; one-hot and encoded grant.
module rr_arbiter
    import mem_sched_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin : pick
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_access_scheduler.sv
// Single-port BRAM scheduler: capped fixed priority for port 0,
// round-robin for the rest, one transaction in flight.
module mem_access_scheduler
    import mem_sched_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic                   clk,
    input logic                   res,
    mem_access_scheduler_if.slave bus
);
    localparam int AW  = ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int IW  = idx_w(N_REQ);
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            we_q, we_d;
    logic [MAW-1:0]  waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [N_REQ-1:0] nreq, arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic             pick0;
    logic [AW-1:0]    sel_addr;

    // Port 0 never takes part in round-robin.
    assign nreq  = bus.req_valid & ~N_REQ'(1);
    assign pick0 = bus.req_valid[0] &&
                   (streak_q < SW'(STARVE_LIMIT) || !arb_any);
    assign bus.busy = (state_q != IDLE);

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req_i (nreq),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_d     = rr_q;
        streak_d = streak_q;
        we_d     = we_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        sel_addr = '0;

        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (pick0 || arb_any) begin
                    g_d           = pick0 ? '0 : arb_idx;
                    bus.req_ready = pick0 ? N_REQ'(1) : arb_gnt;
                    sel_addr      = bus.req_addr[g_d*AW +: AW];
                    we_d          = bus.req_we[g_d];
                    waddr_d       = sel_addr[2 +: MAW];
                    wdata_d       = bus.req_wdata[g_d*DW +: DW];
                    wstrb_d       = bus.req_wstrb[g_d*4 +: 4];
                    rdata_d       = '0;
                    err_d = 64'(sel_addr) >= 64'(MEM_DEPTH) * 64'd4;
                    state_d = err_d ? RESP : ISSUE;
                    if (pick0) begin
                        if (!arb_any)
                            streak_d = '0;
                        else if (streak_q != SW'(STARVE_LIMIT))
                            streak_d = streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                        rr_d = (arb_idx == IW'(N_REQ - 1)) ?
                               IW'(1) : arb_idx + IW'(1);
                    end
                end
            end
            ISSUE: begin
                bus.mem_en    = 1'b1;
                bus.mem_addr  = waddr_q;
                bus.mem_wdata = wdata_q;
                bus.mem_we    = we_q ? wstrb_q : 4'b0;
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = 2'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                bus.rsp_valid[g_q] = 1'b1;
                bus.rsp_rdata      = rdata_q;
                bus.rsp_err        = err_q;
                if (bus.rsp_ready[g_q]) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_q     <= IW'(1);
            streak_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            streak_q <= streak_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
